// File: rtl/snake_dir_queue.sv
// snake_dir_queue: decodes arrow-key presses into one-hot directions and queues them for the game tick
module snake_dir_queue #(
   parameter int         QDEPTH    = 2,
   parameter logic [8:0] KEY_UP    = 9'h01D,
   parameter logic [8:0] KEY_DOWN  = 9'h01B,
   parameter logic [8:0] KEY_LEFT  = 9'h01C,
   parameter logic [8:0] KEY_RIGHT = 9'h023,
   parameter logic [3:0] INIT_DIR  = 4'b1000,
   localparam int        QW        = $clog2(QDEPTH + 1),
   localparam int        PW        = (QDEPTH > 1) ? $clog2(QDEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_i,
   input  logic          restart_i,
   input  logic          key_valid_i,
   input  logic [8:0]    last_change_i,
   input  logic [511:0]  key_down_i,
   input  logic          tick_i,
   output logic [3:0]    direc_o,
   output logic          dir_update_o,
   output logic [QW-1:0] q_count_o,
   output logic          drop_o
);
   logic [3:0]    mem_q [QDEPTH];
   logic [3:0]    direc_q, direc_d;
   logic [PW-1:0] head_q, head_d, tail;
   logic [QW-1:0] count_q, count_d;
   logic          upd_q, drop_q, drop_d;
   logic [3:0]    cand, head_e, newest, ref_dir, opp;
   logic          press, pop, ok, full, push, flush;
   // Decode the key, pick the reference direction seen after this cycle's pop, and plan FIFO moves
   always_comb begin
      cand    = (last_change_i == KEY_UP)    ? 4'b1000 :
                (last_change_i == KEY_DOWN)  ? 4'b0100 :
                (last_change_i == KEY_LEFT)  ? 4'b0010 :
                (last_change_i == KEY_RIGHT) ? 4'b0001 : 4'b0000;
      press   = key_valid_i & key_down_i[last_change_i] & (cand != 4'b0000);
      pop     = start_i & tick_i & (count_q != '0);
      head_e  = mem_q[head_q];
      newest  = mem_q[PW'((int'(head_q) + int'(count_q) + QDEPTH - 1) % QDEPTH)];
      tail    = PW'((int'(head_q) + int'(count_q)) % QDEPTH);
      ref_dir = (int'(count_q) - int'(pop) > 0) ? newest : pop ? head_e : direc_q;
      opp     = {ref_dir[2], ref_dir[3], ref_dir[0], ref_dir[1]};
      ok      = start_i & ~restart_i & press & (cand != ref_dir) & (cand != opp);
      full    = count_q == QW'(QDEPTH);
      push    = ok & (~full | pop);
      drop_d  = ok & full & ~pop;
      flush   = restart_i | ~start_i;
      direc_d = restart_i ? INIT_DIR : pop ? head_e : direc_q;
      head_d  = flush ? '0 : pop ? PW'((int'(head_q) + 1) % QDEPTH) : head_q;
      count_d = flush ? '0 : QW'(int'(count_q) + int'(push) - int'(pop));
   end
   // Direction, pointers, occupancy and the one-cycle status pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         direc_q <= INIT_DIR;
         head_q  <= '0;
         count_q <= '0;
         upd_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         direc_q <= direc_d;
         head_q  <= head_d;
         count_q <= count_d;
         upd_q   <= direc_d != direc_q;
         drop_q  <= drop_d;
      end
   end
   // FIFO storage; a push while full and popping lands in the slot just vacated by the head
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[tail] <= cand;
      end
   end
   assign direc_o      = direc_q;
   assign dir_update_o = upd_q;
   assign q_count_o    = count_q;
   assign drop_o       = drop_q;
endmodule

// File: tb/tb_snake_dir_queue.sv
// tb_snake_dir_queue: directed checks of key decode, legality, queueing, restart and reset
module tb_snake_dir_queue;
   logic         clk = 0, rst = 1, start = 0, restart = 0, key_valid = 0, tick = 0;
   logic [8:0]   last_change = '0;
   logic [511:0] kd = '0;
   logic [3:0]   direc;
   logic         upd, drop;
   logic [1:0]   qc;
   int           nvec = 0, nerr = 0;

   snake_dir_queue dut (
      .clk(clk), .rst(rst), .start_i(start), .restart_i(restart), .key_valid_i(key_valid),
      .last_change_i(last_change), .key_down_i(kd), .tick_i(tick),
      .direc_o(direc), .dir_update_o(upd), .q_count_o(qc), .drop_o(drop)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [8:0] code, input logic down, input logic tk);
      key_valid = 1; last_change = code; kd[code] = down; tick = tk;
      cyc();
      key_valid = 0; kd[code] = 0; tick = 0;
   endtask

   task automatic do_tick();
      tick = 1;
      cyc();
      tick = 0;
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic test_reset();
      #12;
      chk("reset direc", direc, 4'b1000);
      chk("reset q_count", {2'b0, qc}, 4'd0);
      chk("reset dir_update", {3'b0, upd}, 4'd0);
      chk("reset drop", {3'b0, drop}, 4'd0);
      @(posedge clk); #1 rst = 0; start = 1;
   endtask

   task automatic test_push_pop();
      press(9'h023, 1, 0);
      chk("pp q after push", {2'b0, qc}, 4'd1);
      chk("pp direc before tick", direc, 4'b1000);
      do_tick();
      chk("pp direc after tick", direc, 4'b0001);
      chk("pp dir_update pulse", {3'b0, upd}, 4'd1);
      chk("pp q after pop", {2'b0, qc}, 4'd0);
      cyc();
      chk("pp dir_update clears", {3'b0, upd}, 4'd0);
   endtask

   task automatic test_reverse();
      restart = 1; cyc(); restart = 0;
      chk("rev restart direc", direc, 4'b1000);
      chk("rev restart update", {3'b0, upd}, 4'd1);
      press(9'h01B, 1, 0);
      chk("rev down rejected q", {2'b0, qc}, 4'd0);
      chk("rev no drop", {3'b0, drop}, 4'd0);
      do_tick();
      chk("rev direc holds", direc, 4'b1000);
      chk("rev empty tick no update", {3'b0, upd}, 4'd0);
   endtask

   task automatic test_full();
      press(9'h01C, 1, 0);
      press(9'h01D, 1, 0);
      chk("full q=2", {2'b0, qc}, 4'd2);
      chk("full no drop yet", {3'b0, drop}, 4'd0);
      press(9'h01C, 1, 0);
      chk("full drop pulse", {3'b0, drop}, 4'd1);
      chk("full q stays 2", {2'b0, qc}, 4'd2);
      cyc();
      chk("full drop clears", {3'b0, drop}, 4'd0);
      do_tick();
      chk("full first pop", direc, 4'b0010);
      chk("full q=1", {2'b0, qc}, 4'd1);
      do_tick();
      chk("full second pop", direc, 4'b1000);
      chk("full q=0", {2'b0, qc}, 4'd0);
   endtask

   task automatic test_back_to_back();
      press(9'h01C, 1, 0);
      press(9'h01B, 1, 0);
      chk("b2b q=2", {2'b0, qc}, 4'd2);
      press(9'h023, 1, 1);
      chk("b2b head popped", direc, 4'b0010);
      chk("b2b q stays 2", {2'b0, qc}, 4'd2);
      chk("b2b no drop", {3'b0, drop}, 4'd0);
      do_tick();
      chk("b2b second", direc, 4'b0100);
      do_tick();
      chk("b2b tail entry", direc, 4'b0001);
      chk("b2b drained", {2'b0, qc}, 4'd0);
   endtask

   task automatic test_ignored();
      press(9'h015, 1, 0);
      chk("ign unknown code", {2'b0, qc}, 4'd0);
      press(9'h01D, 0, 0);
      chk("ign release", {2'b0, qc}, 4'd0);
      chk("ign direc", direc, 4'b0001);
   endtask

   task automatic test_restart();
      press(9'h01D, 1, 0);
      press(9'h01C, 1, 0);
      chk("rst q=2", {2'b0, qc}, 4'd2);
      restart = 1; tick = 1; cyc(); restart = 0; tick = 0;
      chk("restart direc", direc, 4'b1000);
      chk("restart update", {3'b0, upd}, 4'd1);
      chk("restart flush", {2'b0, qc}, 4'd0);
      start = 0;
      press(9'h01C, 1, 0);
      chk("paused no push", {2'b0, qc}, 4'd0);
      start = 1;
      press(9'h023, 1, 0);
      press(9'h01D, 1, 0);
      do_tick();
      chk("pre-rst direc", direc, 4'b0001);
      chk("pre-rst update", {3'b0, upd}, 4'd1);
      chk("pre-rst q", {2'b0, qc}, 4'd1);
      #1 rst = 1;
      #1;
      chk("async rst direc", direc, 4'b1000);
      chk("async rst q", {2'b0, qc}, 4'd0);
      chk("async rst update", {3'b0, upd}, 4'd0);
      chk("async rst drop", {3'b0, drop}, 4'd0);
   endtask

   initial begin
      test_reset();
      test_push_pop();
      test_reverse();
      test_full();
      test_back_to_back();
      test_ignored();
      test_restart();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
